// File: rtl/step_controller_if.sv
// Push-button step interface between the pulse generators (master) and the
// step controller (slave).
//
// Signals:
//   step_pulse  master->slave  one-cycle single-step / burst request
//   run_pulse   master->slave  one-cycle free-run toggle
//   burst_sel   master->slave  level, step_pulse requests a burst when high
//   halt        master->slave  level from the core's halt/break decode
//   cpu_en      slave->master  processor clock-enable
//   busy        slave->master  controller not idle
//   step_count  slave->master  number of cycles with cpu_en high (wraps)
interface step_controller_if #(
   parameter int unsigned CNT_W = 16
) ();

   logic             step_pulse;
   logic             run_pulse;
   logic             burst_sel;
   logic             halt;
   logic             cpu_en;
   logic             busy;
   logic [CNT_W-1:0] step_count;

   modport master (
      output step_pulse, run_pulse, burst_sel, halt,
      input  cpu_en, busy, step_count
   );

   modport slave (
      input  step_pulse, run_pulse, burst_sel, halt,
      output cpu_en, busy, step_count
   );

endinterface

// File: rtl/step_controller.sv
// Step controller: turns single-cycle button pulses into a processor
// clock-enable. Supports single step, fixed-length burst and free-run with a
// divided enable rate, and counts the issued enables for the display.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   ctrl   step_controller_if.slave (pulses/levels in, cpu_en/busy/step_count out)
//
// Build option: define STEP_PENDING_EN to remember one step_pulse arriving
// during STEP or BURST and service it once the controller is idle again.
module step_controller #(
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned RUN_DIV   = 4,
   parameter int unsigned CNT_W     = 16
) (
   input logic              clk,
   input logic              reset,
   step_controller_if.slave ctrl
);

   localparam logic [7:0] BurstLen   = 8'(BURST_LEN);
   localparam logic [7:0] RunDivLast = 8'(RUN_DIV - 1);

   typedef enum logic [1:0] {StIdle, StStep, StBurst, StRun} state_e;

   state_e           state_q;
   logic [7:0]       rem_q;
   logic [7:0]       div_q;
   logic [CNT_W-1:0] cnt_q;
   logic             en;

   // Effective step request seen in IDLE (live pulse or a stored one).
   logic req_step;
   logic req_sel;

`ifdef STEP_PENDING_EN
   logic pend_q;
   logic pend_sel_q;

   // A stored request takes precedence over a live pulse in the same cycle.
   always_comb begin
      req_step = ctrl.step_pulse | pend_q;
      req_sel  = pend_q ? pend_sel_q : ctrl.burst_sel;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q     <= 1'b0;
         pend_sel_q <= 1'b0;
      end else begin
         unique case (state_q)
            StStep, StBurst: begin
               // Only the first pulse is kept; later ones are dropped.
               if (ctrl.step_pulse && !pend_q) begin
                  pend_q     <= 1'b1;
                  pend_sel_q <= ctrl.burst_sel;
               end
            end
            // IDLE consumes the request (serviced or refused); RUN discards it.
            StIdle, StRun: pend_q <= 1'b0;
            default:       pend_q <= 1'b0;
         endcase
      end
   end
`else
   always_comb begin
      req_step = ctrl.step_pulse;
      req_sel  = ctrl.burst_sel;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         rem_q   <= '0;
         div_q   <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // RUN beats any step request; halt only blocks RUN and BURST.
               if (ctrl.run_pulse && !ctrl.halt) begin
                  state_q <= StRun;
                  div_q   <= '0;
               end else if (req_step && req_sel && !ctrl.halt) begin
                  state_q <= StBurst;
                  rem_q   <= BurstLen;
               end else if (req_step && !req_sel) begin
                  state_q <= StStep;
               end
            end
            StStep: state_q <= StIdle;
            StBurst: begin
               if (ctrl.halt || ctrl.run_pulse || rem_q == 8'd1) begin
                  state_q <= StIdle;
                  rem_q   <= '0;
               end else begin
                  rem_q <= rem_q - 8'd1;
               end
            end
            StRun: begin
               if (ctrl.run_pulse || ctrl.halt) begin
                  state_q <= StIdle;
                  div_q   <= '0;
               end else if (div_q == RunDivLast) begin
                  div_q <= '0;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Moore decode: registered state and divider only.
   always_comb begin
      en = 1'b0;
      unique case (state_q)
         StIdle:  en = 1'b0;
         StStep:  en = 1'b1;
         StBurst: en = 1'b1;
         StRun:   en = (div_q == RunDivLast);
         default: en = 1'b0;
      endcase
   end

   assign ctrl.cpu_en     = en;
   assign ctrl.busy       = (state_q != StIdle);
   assign ctrl.step_count = cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller. Expected enables are derived from
// the mode rules directly (enable windows, divided rate, running count).
module tb_step_controller;

   localparam int unsigned BurstLen = 8;
   localparam int unsigned RunDiv   = 4;
   localparam int unsigned CntW     = 4;
   localparam int          CntMod   = 1 << CntW;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;

   always #5 clk = ~clk;

   step_controller_if #(.CNT_W(CntW)) bus ();

   step_controller #(
      .BURST_LEN (BurstLen),
      .RUN_DIV   (RunDiv),
      .CNT_W     (CntW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus.slave)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset          = 1'b1;
      bus.step_pulse = 1'b0;
      bus.run_pulse  = 1'b0;
      bus.burst_sel  = 1'b0;
      bus.halt       = 1'b0;
      repeat (3) cyc();
      total++;
      if (bus.cpu_en !== 1'b0) begin
         bad++; $display("FAIL reset_cpu_en got=%0b want=0", bus.cpu_en);
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy);
      end
      total++;
      if (bus.step_count !== 4'd0) begin
         bad++; $display("FAIL reset_count got=%0d want=0", bus.step_count);
      end
      reset   = 1'b0;
      exp_cnt = 0;
      cyc();
   endtask

   task automatic test_single_step();
      int n;
      n = int'($urandom_range(3, 6));
      for (int s = 0; s < n; s++) begin
         bus.halt       = 1'($urandom_range(0, 1));
         bus.burst_sel  = 1'b0;
         bus.step_pulse = 1'b1;
         cyc();
         bus.step_pulse = 1'b0;
         bus.halt       = 1'b0;
         total++;
         if (bus.cpu_en !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL step_en got en=%0b busy=%0b want 1/1", bus.cpu_en, bus.busy);
         end
         exp_cnt = (exp_cnt + 1) % CntMod;
         cyc();
         total++;
         if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL step_after got en=%0b busy=%0b want 0/0", bus.cpu_en, bus.busy);
         end
         total++;
         if (int'(bus.step_count) != exp_cnt) begin
            bad++; $display("FAIL step_count got=%0d want=%0d", bus.step_count, exp_cnt);
         end
         repeat ($urandom_range(0, 2)) cyc();
      end
   endtask

   // h = enable number during which halt is raised (0: no halt).
   task automatic test_burst();
      for (int t = 0; t < 4; t++) begin
         int  h;
         int  n;
         logic want;
         h = (t == 0) ? 0 : (t == 1) ? 3 : int'($urandom_range(1, BurstLen));
         n = (h == 0) ? int'(BurstLen) : h;
         bus.burst_sel  = 1'b1;
         bus.step_pulse = 1'b1;
         cyc();
         bus.step_pulse = 1'b0;
         bus.burst_sel  = 1'b0;
         for (int i = 1; i <= int'(BurstLen) + 2; i++) begin
            if (i > 1) cyc();
            want = (i <= n);
            total++;
            if (bus.cpu_en !== want) begin
               bad++; $display("FAIL burst_en t=%0d i=%0d got=%0b want=%0b", t, i, bus.cpu_en, want);
            end
            if (i == h) bus.halt = 1'b1;
         end
         bus.halt = 1'b0;
         exp_cnt  = (exp_cnt + n) % CntMod;
         total++;
         if (int'(bus.step_count) != exp_cnt || bus.busy !== 1'b0) begin
            bad++; $display("FAIL burst_end t=%0d got cnt=%0d busy=%0b want cnt=%0d busy=0",
                            t, bus.step_count, bus.busy, exp_cnt);
         end
      end
   endtask

   task automatic test_run();
      for (int t = 0; t < 3; t++) begin
         int   n;
         logic want;
         n = (t == 0) ? 20 : int'($urandom_range(8, 20));
         bus.run_pulse = 1'b1;
         cyc();
         bus.run_pulse = 1'b0;
         for (int i = 1; i <= n; i++) begin
            if (i > 1) cyc();
            want = ((i % int'(RunDiv)) == 0);
            total++;
            if (bus.cpu_en !== want) begin
               bad++; $display("FAIL run_en t=%0d i=%0d got=%0b want=%0b", t, i, bus.cpu_en, want);
            end
            // Step requests while running must be ignored.
            bus.step_pulse = ($urandom_range(0, 3) == 0);
            bus.burst_sel  = 1'($urandom_range(0, 1));
         end
         bus.step_pulse = 1'b0;
         bus.burst_sel  = 1'b0;
         if (t == 2) bus.halt = 1'b1;
         else        bus.run_pulse = 1'b1;
         cyc();
         bus.run_pulse = 1'b0;
         bus.halt      = 1'b0;
         exp_cnt = (exp_cnt + n / int'(RunDiv)) % CntMod;
         for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b0) begin
               bad++; $display("FAIL run_stop t=%0d i=%0d got en=%0b busy=%0b want 0/0",
                               t, i, bus.cpu_en, bus.busy);
            end
            cyc();
         end
         total++;
         if (int'(bus.step_count) != exp_cnt) begin
            bad++; $display("FAIL run_count t=%0d got=%0d want=%0d", t, bus.step_count, exp_cnt);
         end
      end
   endtask

   task automatic test_halt_gating();
      bus.halt      = 1'b1;
      bus.run_pulse = 1'b1;
      cyc();
      bus.run_pulse = 1'b0;
      repeat (RunDiv) begin
         total++;
         if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL halt_run got en=%0b busy=%0b want 0/0", bus.cpu_en, bus.busy);
         end
         cyc();
      end
      bus.burst_sel  = 1'b1;
      bus.step_pulse = 1'b1;
      cyc();
      bus.step_pulse = 1'b0;
      bus.burst_sel  = 1'b0;
      total++;
      if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL halt_burst got en=%0b busy=%0b want 0/0", bus.cpu_en, bus.busy);
      end
      bus.step_pulse = 1'b1;
      cyc();
      bus.step_pulse = 1'b0;
      total++;
      if (bus.cpu_en !== 1'b1) begin
         bad++; $display("FAIL halt_step got=%0b want=1", bus.cpu_en);
      end
      exp_cnt = (exp_cnt + 1) % CntMod;
      cyc();
      total++;
      if (bus.cpu_en !== 1'b0) begin
         bad++; $display("FAIL halt_step_after got=%0b want=0", bus.cpu_en);
      end
      bus.halt = 1'b0;
      // Simultaneous run+step: RUN wins, so no enable on the first cycle.
      bus.run_pulse  = 1'b1;
      bus.step_pulse = 1'b1;
      cyc();
      bus.run_pulse  = 1'b0;
      bus.step_pulse = 1'b0;
      total++;
      if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("FAIL both_first got en=%0b busy=%0b want 0/1", bus.cpu_en, bus.busy);
      end
      repeat (RunDiv - 1) cyc();
      total++;
      if (bus.cpu_en !== 1'b1) begin
         bad++; $display("FAIL both_run_en got=%0b want=1", bus.cpu_en);
      end
      exp_cnt = (exp_cnt + 1) % CntMod;
      bus.run_pulse = 1'b1;
      cyc();
      bus.run_pulse = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || int'(bus.step_count) != exp_cnt) begin
         bad++; $display("FAIL both_stop got busy=%0b cnt=%0d want 0/%0d",
                         bus.busy, bus.step_count, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      exp_cnt = 0;
      cyc();
      for (int s = 0; s < 17; s++) begin
         bus.step_pulse = 1'b1;
         cyc();
         bus.step_pulse = 1'b0;
         exp_cnt = (exp_cnt + 1) % CntMod;
         cyc();
      end
      total++;
      if (int'(bus.step_count) != exp_cnt) begin
         bad++; $display("FAIL wrap_count got=%0d want=%0d", bus.step_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      bus.burst_sel  = 1'b1;
      bus.step_pulse = 1'b1;
      cyc();
      bus.step_pulse = 1'b0;
      bus.burst_sel  = 1'b0;
      cyc();
      #2 reset = 1'b1;
      #1;
      total++;
      if (bus.cpu_en !== 1'b0 || bus.busy !== 1'b0 || bus.step_count !== 4'd0) begin
         bad++; $display("FAIL reset_mid got en=%0b busy=%0b cnt=%0d want 0/0/0",
                         bus.cpu_en, bus.busy, bus.step_count);
      end
      cyc();
      reset   = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < BurstLen; i++) begin
         cyc();
         total++;
         if (bus.cpu_en !== 1'b0) begin
            bad++; $display("FAIL reset_mid_after i=%0d got=%0b want=0", i, bus.cpu_en);
         end
      end
   endtask

   task automatic test_pending();
      int   extra;
      logic want;
`ifdef STEP_PENDING_EN
      extra = 1;
`else
      extra = 0;
`endif
      bus.burst_sel  = 1'b1;
      bus.step_pulse = 1'b1;
      cyc();
      bus.step_pulse = 1'b0;
      bus.burst_sel  = 1'b0;
      for (int i = 1; i <= int'(BurstLen) + 4; i++) begin
         if (i > 1) cyc();
         bus.step_pulse = 1'b0;
         want = (i <= int'(BurstLen)) || (extra == 1 && i == int'(BurstLen) + 2);
         total++;
         if (bus.cpu_en !== want) begin
            bad++; $display("FAIL pending_en i=%0d got=%0b want=%0b", i, bus.cpu_en, want);
         end
         if (i == 4) bus.step_pulse = 1'b1;
      end
      exp_cnt = (exp_cnt + int'(BurstLen) + extra) % CntMod;
      total++;
      if (int'(bus.step_count) != exp_cnt) begin
         bad++; $display("FAIL pending_count got=%0d want=%0d", bus.step_count, exp_cnt);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_step();
      test_burst();
      test_run();
      test_halt_gating();
      test_wrap();
      test_reset_mid_burst();
      test_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Consumer end of the push-button pulse interface: takes single-cycle pulses from the button pulse generators and turns them into a processor clock-enable (cpu_en).
- Modes: single step, fixed-length burst, free-run with a divided enable rate.
- Sits between the button-pulse logic and the single-cycle MIPS core's state-element enables.
- Also reports an enable count for the display.

Parameters:
- BURST_LEN, 8: number of cpu_en cycles per burst; legal range 1..255.
- RUN_DIV, 4: free-run issues one cpu_en every RUN_DIV clocks; legal range 1..255 (1 = every clock).
- CNT_W, 16: width of step_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_pulse  in  1  one-cycle pulse; request a single step, or a burst when burst_sel=1.
- run_pulse  in  1  one-cycle pulse; toggle free-run.
- burst_sel  in  1  level; selects burst instead of single step for step_pulse.
- halt  in  1  level from core (halt/break decode); stops burst or run.
- cpu_en  out  1  processor clock-enable.
- busy  out  1  high whenever state != IDLE.
- step_count  out  CNT_W  count of cycles with cpu_en=1.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; cpu_en=0; busy=0; step_count=0.
  - Burst counter (rem) and divider counter (div) cleared.
  - Reset mid-burst or mid-run aborts with no further cpu_en.
- cpu_en is a Moore output decoded from registered state and counters only; no input-to-output combinational path.
- Latency: a pulse sampled at edge k gives its first cpu_en in cycle k+1.
- State IDLE (cpu_en=0). Priority order:
  - run_pulse & !halt -> RUN; div=0.
  - else step_pulse & burst_sel & !halt -> BURST; rem=BURST_LEN.
  - else step_pulse & !burst_sel -> STEP. Allowed even with halt=1, so the user can step past a halt.
  - else stay IDLE.
  - run_pulse with halt=1: ignored. step_pulse & burst_sel with halt=1: ignored.
- State STEP:
  - cpu_en=1 for exactly one cycle.
  - Next state unconditionally IDLE.
- State BURST:
  - cpu_en=1 every cycle; rem decrements each cycle.
  - rem==1 -> IDLE. Exactly BURST_LEN enables are issued.
  - halt=1 or run_pulse=1 -> IDLE next edge. The cycle in which the abort is sampled still has cpu_en=1.
- State RUN:
  - div counts 0..RUN_DIV-1 and wraps to 0.
  - cpu_en=1 only when div==RUN_DIV-1.
  - run_pulse or halt -> IDLE; div=0.
  - step_pulse is ignored.
- Pulse dropping: step_pulse or run_pulse arriving in STEP, or step_pulse arriving in BURST or RUN, is dropped (no queue), except as stated above and under the optional feature.
- step_count:
  - Increments by 1 on every clock with cpu_en=1.
  - Wraps modulo 2^CNT_W (0xFFFF+1 -> 0x0000 at default width).
  - No other clear than reset.
- busy is a combinational decode of state only.
- Simultaneous run_pulse and step_pulse in IDLE: RUN wins; the step pulse is lost.

Optional Feature:
- Macro: STEP_PENDING_EN.
- When defined:
  - A 1-bit pending flag captures a step_pulse arriving in STEP or BURST, along with the burst_sel value at that moment.
  - On return to IDLE, the pending request is serviced on the next edge as if just received: the halt rules still apply, and run_pulse still has priority. The flag is then cleared.
  - A second pulse while pending is already set is dropped.
  - The flag is cleared by reset and on entry to RUN.
- When not defined: no pending storage; all such pulses are dropped as in Behaviour.

Test Plan:
- Single step: reset, release; step_pulse=1 for one cycle with burst_sel=0.
  - -> cpu_en high for exactly one cycle, one clock after the pulse; step_count=1; busy high that cycle only.
- Burst with halt: BURST_LEN=8; step_pulse with burst_sel=1.
  - -> 8 consecutive cpu_en cycles; step_count 0->8; back to IDLE.
  - Repeat with halt raised during the 3rd enable -> exactly 3 enables.
- Free-run: RUN_DIV=4; run_pulse; observe 20 clocks.
  - -> cpu_en on clocks 4, 8, 12, 16, 20 after entry.
  - A second run_pulse -> IDLE, no further enables.
  - step_pulse during RUN has no effect.
- Halt gating: halt=1 in IDLE.
  - run_pulse -> stays IDLE.
  - burst request -> stays IDLE.
  - single step -> one cpu_en.
  - Simultaneous run_pulse+step_pulse with halt=0 -> RUN entered; no STEP.
- Wrap: CNT_W=4; issue 17 single steps -> step_count=1.
  - Assert reset mid-burst (after 2 enables) -> cpu_en=0 immediately; count=0.
- Pending: with STEP_PENDING_EN, step_pulse during the 4th burst cycle -> a single step follows 1 clock after the burst ends.
  - Without the macro -> no extra enable.
